// File: rtl/x1_input_conditioner_pkg.sv
// Shared encodings for the x1 input conditioner and the downstream x1-driven controller.
package x1_input_conditioner_pkg;

    // Conditioner FSM encodings; only one bit differs between each state and its check state.
    localparam logic [1:0] ST_STABLE_LO = 2'b00;
    localparam logic [1:0] ST_CHK_HI    = 2'b01;
    localparam logic [1:0] ST_STABLE_HI = 2'b11;
    localparam logic [1:0] ST_CHK_LO    = 2'b10;

    typedef enum logic [1:0] {
        StStableLo = ST_STABLE_LO,
        StChkHi    = ST_CHK_HI,
        StStableHi = ST_STABLE_HI,
        StChkLo    = ST_CHK_LO
    } cond_state_e;

    // Existing controller state encodings.
    localparam logic [1:0] CTRL_S1 = 2'b00;
    localparam logic [1:0] CTRL_S2 = 2'b01;
    localparam logic [1:0] CTRL_S3 = 2'b10;
    localparam logic [1:0] CTRL_S4 = 2'b11;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 16;

endpackage

// File: rtl/x1_input_conditioner_sync_chain.sv
// Multi-flop synchronizer for an asynchronous pad input; resets to a chosen level.
module x1_input_conditioner_sync_chain #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          RESET_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/x1_input_conditioner.sv
// Synchronizes and debounces a bouncy pad input into a clean x1 level with rise/fall strobes
// and a saturating count of aborted transitions.
module x1_input_conditioner
    import x1_input_conditioner_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = 5,
    parameter bit          RESET_LEVEL     = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_raw,
    input  logic       clr_stats,
    output logic       x1,
    output logic       x1_rise,
    output logic       x1_fall,
    output logic [7:0] bounce_cnt
);

    localparam cond_state_e      RESET_STATE = RESET_LEVEL ? StStableHi : StStableLo;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit               IMMEDIATE   = (DEBOUNCE_CYCLES == 1);

    logic s;

    x1_input_conditioner_sync_chain #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_LEVEL(RESET_LEVEL)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn_raw),
        .q    (s)
    );

    cond_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x1_q, x1_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [7:0]       bounce_q, bounce_d;
    logic             bounce_inc;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x1_d       = x1_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        bounce_inc = 1'b0;
        unique case (state_q)
            StStableLo: begin
                cnt_d = '0;
                if (s) begin
                    if (IMMEDIATE) begin
                        state_d = StStableHi;
                        x1_d    = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = StChkHi;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            StChkHi: begin
                if (!s) begin
                    state_d    = StStableLo;
                    cnt_d      = '0;
                    bounce_inc = 1'b1;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = StStableHi;
                    cnt_d   = '0;
                    x1_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StStableHi: begin
                cnt_d = '0;
                if (!s) begin
                    if (IMMEDIATE) begin
                        state_d = StStableLo;
                        x1_d    = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = StChkLo;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            StChkLo: begin
                if (s) begin
                    state_d    = StStableHi;
                    cnt_d      = '0;
                    bounce_inc = 1'b1;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = StStableLo;
                    cnt_d   = '0;
                    x1_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = StStableLo;
                cnt_d   = '0;
                x1_d    = 1'b0;
            end
        endcase
    end

    // Clear takes priority over a coincident increment.
    always_comb begin
        bounce_d = bounce_q;
        if (clr_stats) begin
            bounce_d = '0;
        end else if (bounce_inc && (bounce_q != 8'hFF)) begin
            bounce_d = bounce_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RESET_STATE;
            cnt_q    <= '0;
            x1_q     <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            bounce_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x1_q     <= x1_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            bounce_q <= bounce_d;
        end
    end

    assign x1         = x1_q;
    assign x1_rise    = rise_q;
    assign x1_fall    = fall_q;
    assign bounce_cnt = bounce_q;

endmodule

// File: tb/tb_x1_input_conditioner.sv
// Directed bench: one conditioner with DEBOUNCE_CYCLES=4 and one with DEBOUNCE_CYCLES=1.
module tb_x1_input_conditioner;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn, clr;
    logic       x1, rise, fall;
    logic [7:0] bcnt;
    logic       btn1;
    logic       x1_1, rise_1, fall_1;
    logic [7:0] bcnt_1;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    x1_input_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W(5),
        .RESET_LEVEL(1'b0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn),
        .clr_stats (clr),
        .x1        (x1),
        .x1_rise   (rise),
        .x1_fall   (fall),
        .bounce_cnt(bcnt)
    );

    x1_input_conditioner #(
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(1),
        .CNT_W(5),
        .RESET_LEVEL(1'b0)
    ) dut1 (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn1),
        .clr_stats (1'b0),
        .x1        (x1_1),
        .x1_rise   (rise_1),
        .x1_fall   (fall_1),
        .bounce_cnt(bcnt_1)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Three-cycle high pulse that must be rejected; reports whether any output moved.
    task automatic pulse3(output logic saw);
        saw = 1'b0;
        btn = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) btn = 1'b0;
            tick(1);
            if (x1 || rise || fall) saw = 1'b1;
        end
    endtask

    logic saw, saw_any;

    initial begin
        reset = 1'b1;
        btn   = 1'b0;
        clr   = 1'b0;
        btn1  = 1'b0;
        #1;
        check("reset_x1", {7'd0, x1}, 8'd0);
        check("reset_rise", {7'd0, rise}, 8'd0);
        check("reset_fall", {7'd0, fall}, 8'd0);
        check("reset_bcnt", bcnt, 8'd0);
        tick(2);
        reset = 1'b0;
        tick(2);

        // Clean press
        btn = 1'b1;
        tick(5);
        check("press_e5_x1", {7'd0, x1}, 8'd0);
        tick(1);
        check("press_e6_x1", {7'd0, x1}, 8'd1);
        check("press_e6_rise", {7'd0, rise}, 8'd1);
        check("press_e6_fall", {7'd0, fall}, 8'd0);
        tick(1);
        check("press_e7_rise", {7'd0, rise}, 8'd0);
        check("press_e7_x1", {7'd0, x1}, 8'd1);
        check("press_bcnt", bcnt, 8'd0);
        tick(3);

        // Release
        btn = 1'b0;
        tick(5);
        check("rel_e5_x1", {7'd0, x1}, 8'd1);
        check("rel_e5_fall", {7'd0, fall}, 8'd0);
        tick(1);
        check("rel_e6_x1", {7'd0, x1}, 8'd0);
        check("rel_e6_fall", {7'd0, fall}, 8'd1);
        check("rel_e6_rise", {7'd0, rise}, 8'd0);
        tick(1);
        check("rel_e7_fall", {7'd0, fall}, 8'd0);
        check("rel_e7_rise", {7'd0, rise}, 8'd0);
        tick(3);

        // Bounce rejection and saturation
        pulse3(saw);
        check("bounce1_quiet", {7'd0, saw}, 8'd0);
        check("bounce1_bcnt", bcnt, 8'd1);
        saw_any = 1'b0;
        for (int i = 0; i < 299; i++) begin
            pulse3(saw);
            saw_any |= saw;
        end
        check("bounce300_quiet", {7'd0, saw_any}, 8'd0);
        check("bounce300_bcnt", bcnt, 8'd255);

        // Clear coincides with abort edge
        btn = 1'b1;
        tick(3);
        btn = 1'b0;
        tick(2);
        check("clr_pre_bcnt", bcnt, 8'd255);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr_wins_bcnt", bcnt, 8'd0);
        tick(2);
        pulse3(saw);
        check("clr_resume_bcnt", bcnt, 8'd1);

        // Reset mid CHK_HI (cnt=2 after edge 4)
        btn = 1'b1;
        tick(4);
        reset = 1'b1;
        #1;
        check("rst_mid_x1", {7'd0, x1}, 8'd0);
        check("rst_mid_rise", {7'd0, rise}, 8'd0);
        check("rst_mid_fall", {7'd0, fall}, 8'd0);
        check("rst_mid_bcnt", bcnt, 8'd0);
        tick(1);
        reset = 1'b0;
        tick(5);
        check("rst_after_e5_x1", {7'd0, x1}, 8'd0);
        check("rst_after_e5_rise", {7'd0, rise}, 8'd0);
        tick(1);
        check("rst_after_e6_x1", {7'd0, x1}, 8'd1);
        check("rst_after_e6_rise", {7'd0, rise}, 8'd1);

        // DEBOUNCE_CYCLES = 1
        btn1 = 1'b1;
        tick(2);
        check("d1_e2_x1", {7'd0, x1_1}, 8'd0);
        tick(1);
        check("d1_e3_x1", {7'd0, x1_1}, 8'd1);
        check("d1_e3_rise", {7'd0, rise_1}, 8'd1);
        tick(1);
        check("d1_e4_rise", {7'd0, rise_1}, 8'd0);
        btn1 = 1'b0;
        tick(1);
        btn1 = 1'b1;
        tick(1);
        check("d1_glitch_e2_x1", {7'd0, x1_1}, 8'd1);
        tick(1);
        check("d1_glitch_e3_x1", {7'd0, x1_1}, 8'd0);
        check("d1_glitch_e3_fall", {7'd0, fall_1}, 8'd1);
        check("d1_glitch_e3_rise", {7'd0, rise_1}, 8'd0);
        tick(1);
        check("d1_glitch_e4_x1", {7'd0, x1_1}, 8'd1);
        check("d1_glitch_e4_rise", {7'd0, rise_1}, 8'd1);
        check("d1_glitch_e4_fall", {7'd0, fall_1}, 8'd0);
        tick(1);
        check("d1_glitch_e5_rise", {7'd0, rise_1}, 8'd0);
        check("d1_bcnt", bcnt_1, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
